// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and defaults for the BRAM port arbiter: FSM states, requester ids,
// default bus widths.
package bram_port_arbiter_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side handshakes for both ports plus the BRAM port-A bus.
// The master modport is the environment (requesters and the BRAM); slave is the arbiter.
interface bram_port_arbiter_if
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_done;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_done;
  logic [DW-1:0] p1_rdata;

  logic          bram_rsta;
  logic          bram_ena;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;
  logic [DW-1:0] bram_douta;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_done, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_done, p1_rdata,
    input  bram_rsta, bram_ena, bram_wea, bram_addra, bram_dina,
    output bram_douta
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_done, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_done, p1_rdata,
    output bram_rsta, bram_ena, bram_wea, bram_addra, bram_dina,
    input  bram_douta
  );

endinterface

// File: rtl/bram_port_arbiter_arb_pick.sv
// Winner select for the shared BRAM: load/store first, with a saturating
// starvation counter that forces a fetch grant after STARVE_MAX back-to-back misses.
module bram_arb_pick
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  p0_req_i,
  input  logic  p1_req_i,
  input  logic  idle_i,
  input  logic  grant_i,
  output port_e winner_o
);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          at_max;
  port_e         winner;

  always_comb begin
    at_max       = (starve_cnt_q == CW'(STARVE_MAX));
    winner       = (p1_req_i && !(p0_req_i && at_max)) ? PORT_LS : PORT_IF;
    starve_cnt_d = starve_cnt_q;
    if (grant_i) begin
      // Only a port-1 grant taken while fetch is waiting counts as a miss.
      if (winner == PORT_IF || !p0_req_i) begin
        starve_cnt_d = '0;
      end else if (!at_max) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end else if (idle_i && !p0_req_i) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign winner_o = winner;

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-requester front end for a single-port BRAM: one access at a time, sequenced
// IDLE -> ISSUE -> (WAIT) -> DONE, with read data returned to the winning port.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                clka,
  input logic                rsta_n,
  bram_port_arbiter_if.slave bus
);
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  port_e         winner_q, winner_d;
  port_e         pick;
  logic [1:0]    lat_q, lat_d;
  logic          ena_q, ena_d;
  logic          wea_q, wea_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;
  logic          idle;
  logic          grant;

  assign idle  = (state_q == ST_IDLE);
  assign grant = idle && (bus.p0_req || bus.p1_req);

  bram_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk_i   (clka),
    .rst_ni  (rsta_n),
    .p0_req_i(bus.p0_req),
    .p1_req_i(bus.p1_req),
    .idle_i  (idle),
    .grant_i (grant),
    .winner_o(pick)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    lat_d    = lat_q;
    ena_d    = ena_q;
    wea_d    = wea_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;

    case (state_q)
      ST_IDLE: begin
        ena_d = 1'b0;
        wea_d = 1'b0;
        if (grant) begin
          winner_d = pick;
          ena_d    = 1'b1;
          state_d  = ST_ISSUE;
          if (pick == PORT_LS) begin
            wea_d  = bus.p1_we;
            addr_d = bus.p1_addr;
            din_d  = bus.p1_wdata;
          end else begin
            wea_d  = bus.p0_we;
            addr_d = bus.p0_addr;
            din_d  = bus.p0_wdata;
          end
        end
      end
      ST_ISSUE: begin
        // wea_q still reflects the access the BRAM samples on this edge.
        ena_d   = 1'b0;
        wea_d   = 1'b0;
        lat_d   = LAT_INIT;
        state_d = wea_q ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d = ST_DONE;
          if (winner_q == PORT_LS) begin
            rd1_d = bus.bram_douta;
          end else begin
            rd0_d = bus.bram_douta;
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q  <= ST_IDLE;
      winner_q <= PORT_IF;
      lat_q    <= '0;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      lat_q    <= lat_d;
      ena_q    <= ena_d;
      wea_q    <= wea_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  assign bus.p0_done    = (state_q == ST_DONE) && (winner_q == PORT_IF);
  assign bus.p1_done    = (state_q == ST_DONE) && (winner_q == PORT_LS);
  assign bus.p0_rdata   = rd0_q;
  assign bus.p1_rdata   = rd1_q;
  assign bus.bram_rsta  = ~rsta_n;
  assign bus.bram_ena   = ena_q;
  assign bus.bram_wea   = wea_q;
  assign bus.bram_addra = addr_q;
  assign bus.bram_dina  = din_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM models, a transaction-level reference model
// compared every cycle, and directed vectors with hand-computed latencies and data.
module tb_bram_port_arbiter;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int          SMAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

  bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(SMAX)) u_dut (
    .clka(clk), .rsta_n(rst_n), .bus(bus.slave)
  );
  bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .STARVE_MAX(SMAX)) u_dut2 (
    .clka(clk), .rsta_n(rst_n), .bus(bus2.slave)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] initv(input int i);
    if (i == 1) return 32'h11;
    if (i == 2) return 32'h22;
    return 32'hC0DE_0000 + 32'(i) * 32'h101;
  endfunction

  // BRAM models: 1-cycle and 2-cycle registered read latency.
  logic [DW-1:0] mem1[32];
  logic [DW-1:0] mem2[32];
  logic [DW-1:0] s2;
  always @(posedge clk) begin
    if (bus.bram_ena) begin
      if (bus.bram_wea) mem1[bus.bram_addra] <= bus.bram_dina;
      else bus.bram_douta <= mem1[bus.bram_addra];
    end
  end
  always @(posedge clk) begin
    if (bus2.bram_ena) begin
      if (bus2.bram_wea) mem2[bus2.bram_addra] <= bus2.bram_dina;
      else s2 <= mem2[bus2.bram_addra];
    end
    bus2.bram_douta <= s2;
  end

  // Reference model: one access at a time, done at grant+2 (write) or grant+3 (read).
  logic [DW-1:0] mref[32];
  int   cyc = 0;
  int   free_at = 0;
  int   starve = 0;
  int   done_at[2] = '{-1, -1};
  bit   pend_rd[2];
  logic [31:0] pend_val[2];
  logic [31:0] exp_rd[2] = '{32'h0, 32'h0};
  bit   exp_done[2] = '{1'b0, 1'b0};
  int   w;
  bit   m_we;
  logic [4:0] m_a;
  logic [31:0] m_d;

  always @(posedge clk) begin
    if (!rst_n) begin
      free_at = 0; starve = 0;
      done_at[0] = -1; done_at[1] = -1;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else if (cyc >= free_at) begin
      if (bus.p0_req || bus.p1_req) begin
        w = (bus.p1_req && !(bus.p0_req && starve == SMAX)) ? 1 : 0;
        if (w == 0 || !bus.p0_req) starve = 0;
        else if (starve < SMAX) starve++;
        m_we = (w == 1) ? bus.p1_we    : bus.p0_we;
        m_a  = (w == 1) ? bus.p1_addr  : bus.p0_addr;
        m_d  = (w == 1) ? bus.p1_wdata : bus.p0_wdata;
        if (m_we) begin
          mref[m_a] = m_d; pend_rd[w] = 1'b0; done_at[w] = cyc + 2;
        end else begin
          pend_val[w] = mref[m_a]; pend_rd[w] = 1'b1; done_at[w] = cyc + 3;
        end
        free_at = done_at[w] + 1;
      end else begin
        starve = 0;
      end
    end
    cyc++;
    for (int p = 0; p < 2; p++) begin
      exp_done[p] = (done_at[p] == cyc);
      if (exp_done[p] && pend_rd[p]) exp_rd[p] = pend_val[p];
    end
  end

  bit rec = 1'b0;
  int order[$];
  bit held0 = 1'b0;
  bit held1 = 1'b0;

  always @(negedge clk) begin
    chk("bram_rsta", 32'(bus.bram_rsta), 32'(!rst_n));
    if (!rst_n) begin
      chk("rst_p0_done", 32'(bus.p0_done), 0);
      chk("rst_p1_done", 32'(bus.p1_done), 0);
      chk("rst_p0_rdata", bus.p0_rdata, 0);
      chk("rst_p1_rdata", bus.p1_rdata, 0);
      chk("rst_ena", 32'(bus.bram_ena), 0);
      chk("rst_wea", 32'(bus.bram_wea), 0);
      chk("rst_addra", 32'(bus.bram_addra), 0);
      chk("rst_dina", bus.bram_dina, 0);
      held0 = 1'b0; held1 = 1'b0;
    end else begin
      chk("p0_done", 32'(bus.p0_done), 32'(exp_done[0]));
      chk("p1_done", 32'(bus.p1_done), 32'(exp_done[1]));
      chk("p0_rdata", bus.p0_rdata, exp_rd[0]);
      chk("p1_rdata", bus.p1_rdata, exp_rd[1]);
      // Requester protocol: req stays high from issue until its done pulse.
      assert (!(held0 && !bus.p0_req)) else begin
        nerr++; $display("FAIL p0_req_dropped at %0t", $time);
      end
      assert (!(held1 && !bus.p1_req)) else begin
        nerr++; $display("FAIL p1_req_dropped at %0t", $time);
      end
      held0 = bus.p0_req && !bus.p0_done;
      held1 = bus.p1_req && !bus.p1_done;
      if (rec && bus.p1_done) order.push_back(1);
      if (rec && bus.p0_done) order.push_back(0);
    end
  end

  // Called at posedge+1 of the request's first IDLE cycle; lat counts cycles to done.
  task automatic txn(input int p, input bit we, input logic [4:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd);
    if (p == 0) begin
      bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    end
    lat = -1;
    rd  = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if ((p == 0) ? bus.p0_done : bus.p1_done) begin
        lat = n;
        rd  = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.p0_req = 1'b0;
    else bus.p1_req = 1'b0;
  endtask

  int lat_a, lat_b;
  logic [31:0] rd_a, rd_b;
  int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int run, maxrun;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem1[i] = initv(i); mem2[i] = initv(i); mref[i] = initv(i);
    end
    rst_n = 1'b0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 5'd9; bus.p1_wdata = 32'h99;
    bus2.p0_req = 1'b0; bus2.p0_we = 1'b0; bus2.p0_addr = '0; bus2.p0_wdata = '0;
    bus2.p1_req = 1'b0; bus2.p1_we = 1'b0; bus2.p1_addr = '0; bus2.p1_wdata = '0;

    // Reset held 3 cycles with a pending write; grant starts right after release.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    txn(1, 1'b1, 5'd9, 32'h99, lat_a, rd_a);
    chk("post_reset_write_lat", 32'(lat_a), 2);
    drop(1);
    @(posedge clk); #1;

    // Write then back-to-back read on port 1.
    txn(1, 1'b1, 5'd5, 32'hDEAD_BEEF, lat_a, rd_a);
    chk("write_lat", 32'(lat_a), 2);
    txn(1, 1'b0, 5'd5, 32'h0, lat_a, rd_a);
    drop(1);
    chk("read_lat", 32'(lat_a), 3);
    chk("read_data", rd_a, 32'hDEAD_BEEF);
    chk("p0_rdata_untouched", bus.p0_rdata, 32'h0);
    chk("readback_9", mem1[9], 32'h99);

    // Simultaneous reads: port 1 wins, port 0 follows one full read later.
    fork
      begin txn(1, 1'b0, 5'd2, 32'h0, lat_b, rd_b); drop(1); end
      begin txn(0, 1'b0, 5'd1, 32'h0, lat_a, rd_a); drop(0); end
    join
    chk("sim_p1_lat", 32'(lat_b), 3);
    chk("sim_p1_data", rd_b, 32'h22);
    chk("sim_p0_lat", 32'(lat_a), 7);
    chk("sim_p0_data", rd_a, 32'h11);
    @(posedge clk); #1;

    // Starvation guard with both requesters continuously busy.
    order.delete();
    rec = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) txn(1, 1'b1, 5'(16 + i), 32'(i), lat_b, rd_b);
        drop(1);
      end
      begin
        for (int i = 0; i < 2; i++) txn(0, 1'b0, 5'(1 + i), 32'h0, lat_a, rd_a);
        drop(0);
      end
    join
    rec = 1'b0;
    chk("order_len", 32'(order.size()), 10);
    run = 0; maxrun = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < order.size()) begin
        chk($sformatf("order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
        run = (order[i] == 1) ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
      end
    end
    chk("max_p1_run", 32'(maxrun), 4);
    chk("starve_p0_last", rd_a, 32'h22);
    @(posedge clk); #1;

    // Reset during the WAIT cycle of a port-0 read aborts it.
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 5'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; bus.p0_req = 1'b0;
    @(negedge clk);
    chk("abort_p0_done", 32'(bus.p0_done), 0);
    chk("abort_p0_rdata", bus.p0_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.p0_done), 0);
    end
    @(posedge clk); #1;
    txn(0, 1'b0, 5'd3, 32'h0, lat_a, rd_a);
    drop(0);
    chk("reissue_lat", 32'(lat_a), 3);
    chk("reissue_data", rd_a, 32'hC0DE_0303);

    // Two-cycle read latency build.
    bus2.p1_req = 1'b1; bus2.p1_we = 1'b0; bus2.p1_addr = 5'd7;
    lat_a = -1; rd_a = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus2.p1_done) begin
        lat_a = n; rd_a = bus2.p1_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    bus2.p1_req = 1'b0;
    chk("lat2_read_lat", 32'(lat_a), 4);
    chk("lat2_read_data", rd_a, 32'hC0DE_0707);
    chk("lat2_p0_rdata", bus2.p0_rdata, 32'h0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d vectors, %0d miscompares", nvec, nerr);
    $fatal(1, "watchdog");
  end

endmodule
